// File: rtl/debug_pkg.sv
// Shared definitions for the on-chip debug blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debug_pkg;

  // Trace FSM encoding; the numeric values are visible on the state port.
  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_e;

  localparam int TRC_DATA_W = 32;
  localparam int TRC_DEPTH  = 16;

endpackage

// File: rtl/trace_if.sv
// Capture and readout handshake bundle of the trace buffer.
// Latency: n/a (wires only).
// Backpressure: rd_ready from the consumer; capture side has no stall.
interface trace_if #(
  parameter int DATA_W = debug_pkg::TRC_DATA_W
);
  logic              cap_valid;
  logic [DATA_W-1:0] cap_pc;
  logic [DATA_W-1:0] cap_instr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic              rd_last;

  // Pipeline stage and debug consumer side.
  modport master (
    output cap_valid, cap_pc, cap_instr, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_last
  );

  // Trace buffer side.
  modport slave (
    input  cap_valid, cap_pc, cap_instr, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_last
  );
endinterface

// File: rtl/trace_mem.sv
// Trace storage: DEPTH words, one synchronous write port, one asynchronous read port.
// Latency: write visible the cycle after the edge; read is combinational.
// Backpressure: none; the owner decides when to write.
module trace_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; count/rptr gate what is ever read.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/trace_buffer.sv
// Circular (PC, instruction) trace capture with PC-match trigger and oldest-first readout.
// Latency: capture reflected in count one edge later; readout data is combinational.
// Backpressure: rd_ready stalls readout with outputs held; capture side never stalls.
module trace_buffer
  import debug_pkg::*;
#(
  parameter int DATA_W = TRC_DATA_W,
  parameter int DEPTH  = TRC_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              arm,
  input  logic              stop,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [CNT_W-1:0]  post_count,
  trace_if.slave            bus,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  trc_state_e         state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d, remaining_q, remaining_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   post_sat;
  logic               capturing, cap_en, trig_hit, rd_vld, rd_fire;
  logic [2*DATA_W-1:0] rd_data;

  assign capturing = (state_q == TRC_ARMED) || (state_q == TRC_POST);
  // arm discards any same-cycle capture.
  assign cap_en    = capturing && bus.cap_valid && !arm;
  assign trig_hit  = (state_q == TRC_ARMED) && bus.cap_valid && trig_en &&
                     (bus.cap_pc == trig_pc);
  assign post_sat  = (post_count > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_count;
  assign rd_vld    = (state_q == TRC_DONE) && (count_q != '0);
  assign rd_fire   = rd_vld && bus.rd_ready;

  trace_mem #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (cap_en),
    .wr_addr_i (wptr_q),
    .wr_data_i ({bus.cap_pc, bus.cap_instr}),
    .rd_addr_i (rptr_q),
    .rd_data_o (rd_data)
  );

  // Next-state: arm > stop > capture/trigger > readout.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;

    if (arm) begin
      state_d     = TRC_ARMED;
      wptr_d      = '0;
      count_d     = '0;
      remaining_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (cap_en) begin
        wptr_d = wptr_q + PTR_W'(1);
        if (count_q == CNT_W'(DEPTH)) overflow_d = 1'b1;
        else                          count_d    = count_q + CNT_W'(1);
      end

      if (capturing && stop) begin
        state_d = (count_d == '0) ? TRC_IDLE : TRC_DONE;
      end else if (cap_en) begin
        if (state_q == TRC_ARMED) begin
          if (trig_hit) begin
            if (post_count == '0) begin
              state_d = TRC_DONE;
            end else begin
              state_d     = TRC_POST;
              remaining_d = post_sat;
            end
          end
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = TRC_DONE;
        end
      end else if (rd_fire) begin
        rptr_d  = rptr_q + PTR_W'(1);
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = TRC_IDLE;
      end

      // Point at the oldest surviving entry when capture finishes.
      if ((state_d == TRC_DONE) && (state_q != TRC_DONE)) begin
        rptr_d = wptr_d - count_d[PTR_W-1:0];
      end
    end
  end

  // State, pointer and counter registers; clr clears everything but memory.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= TRC_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.rd_valid = rd_vld;
  assign bus.rd_pc    = rd_vld ? rd_data[2*DATA_W-1:DATA_W] : '0;
  assign bus.rd_instr = rd_vld ? rd_data[DATA_W-1:0] : '0;
  assign bus.rd_last  = rd_vld && (count_q == CNT_W'(1));

  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Parametrised, synthesizable instruction-trace capture unit for the MIPS pipeline. Records (PC, instruction) pairs from one pipeline stage into a circular buffer. Stops after a programmable number of post-trigger entries once a PC-match trigger fires. The captured window is then streamed out oldest-first over a valid/ready port. It replaces file-driven, simulation-only inspection with an on-chip debug block usable in both simulation and hardware.

## Interface
Parameters:
- DATA_W, 32, width of PC and instruction fields
- DEPTH, 16, entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, derived; width of counts

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset; asynchronous and active-high
- arm  in  1  pulse: clear buffer, enter ARMED
- stop  in  1  force end of capture
- cap_valid  in  1  stage holds a valid instruction this cycle
- cap_pc  in  DATA_W  PC of that instruction
- cap_instr  in  DATA_W  instruction word
- trig_en  in  1  enables PC-match trigger
- trig_pc  in  DATA_W  trigger address
- post_count  in  CNT_W  entries to capture after the trigger entry; values >DEPTH-1 saturate to DEPTH-1
- rd_ready  in  1  consumer accepts the current entry
- rd_valid  out  1  entry available
- rd_pc  out  DATA_W  entry PC; 0 when rd_valid=0
- rd_instr  out  DATA_W  entry instruction; 0 when rd_valid=0
- rd_last  out  1  current entry is the final one
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  CNT_W  entries currently held
- overflow  out  1  at least one entry was overwritten since arm

## Operation
- Reset values: state=IDLE, count=0, overflow=0, rd_valid=0, rd_pc=0, rd_instr=0, rd_last=0. Memory contents are not reset.
- Priority: clr > arm > stop > capture/trigger > readout.
- arm in any state: wptr=0, count=0, overflow=0, remaining=0, next state ARMED. Any capture in the same cycle is discarded.
- Capture occurs in ARMED or POST when cap_valid=1:
  - write {cap_pc, cap_instr} at wptr
  - wptr = (wptr+1) mod DEPTH
  - if count==DEPTH: set overflow, count unchanged; else count+1
- Trigger, in ARMED only, when cap_valid & trig_en & cap_pc==trig_pc:
  - the trigger entry itself is written
  - post_count==0 → DONE
  - otherwise → POST with remaining=sat(post_count)
- POST: each capture decrements remaining. The write that takes remaining to 0 moves the state to DONE. Cycles without cap_valid do not decrement.
- stop in ARMED or POST: the same-cycle capture is still written. Next state is DONE, or IDLE if the resulting count is 0. stop in IDLE or DONE is ignored.
- On entry to DONE: rptr = (wptr − count) mod DEPTH, giving the oldest entry.
- DONE readout:
  - rd_valid = count≠0; rd_pc and rd_instr read mem[rptr] combinationally; rd_last = (count==1)
  - transfer on rd_valid & rd_ready: rptr+1 mod DEPTH, count−1
  - the transfer that takes count to 0 moves the state to IDLE
- rd_valid is 0 in IDLE, ARMED, and POST.
- Pointer arithmetic wraps modulo DEPTH. Counts are unsigned and saturate at DEPTH.

## Timing
- All state, pointers, and counters update on the rising edge of clk. clr clears them immediately, with no clock required.
- Capture latency: an entry written at edge N is reflected in count after edge N.
- Trigger with post_count=0: state=DONE and rd_valid=1 in the cycle after the trigger edge.
- Readout: zero-latency data. One entry per cycle with rd_ready held high.
- While rd_valid=1 and rd_ready=0, rd_pc, rd_instr, and rd_last hold stable.
- Reset mid-capture or mid-readout returns the block to the reset values. The next arm behaves as after power-up.

## Structure
- Shared package debug_pkg:
  - state constants TRC_IDLE, TRC_ARMED, TRC_POST, TRC_DONE (2-bit)
  - default DATA_W and DEPTH localparams
- Sub-module trace_mem: DEPTH × 2·DATA_W storage with one synchronous write port and one asynchronous read port. No reset.
- Top-level trace_buffer holds the FSM, wptr/rptr, count, remaining, overflow, and trigger compare.

## Test plan
Directed scenarios, DEPTH=4:
- Reset: clr asserted mid-POST with count=3 → state=0, count=0, overflow=0, rd_valid=0, rd_pc=0 with no clock edge.
- Wrap with trigger, one entry per cycle:
  - setup: arm; trig_pc=0x10, post_count=2; PCs 0x00,0x04,…
  - response: DONE after PC 0x18; overflow=1
  - readout: 0x0C, 0x10, 0x14, 0x18; rd_last only on 0x18; then state=IDLE
- Backpressure: in DONE with rd_ready=0 for 5 cycles → rd_pc fixed at the oldest entry and count unchanged. Then rd_ready=1 → one entry per cycle.
- POST gaps: trigger at 0x20 with post_count=1, then 3 cycles cap_valid=0, then 0x24 → state stays POST until the 0x24 edge. Readout ends with 0x20, 0x24.
- stop without wrap: arm, capture 0x40 and 0x44, stop → readout 0x40, 0x44; overflow=0. stop with count 0 → state IDLE.
- Re-arm during readout: arm while rd_valid=1 with count=3 → next cycle state=ARMED, count=0, rd_valid=0, overflow=0.
